// File: rtl/match_job_scheduler.sv
// Issues (col,row) block-matching jobs in raster order for one frame, throttled by downstream row credits and an in-flight cap.
// job_valid comes only from registered state; reset asserts asynchronously and releases through a 2-flop synchroniser.
module match_job_scheduler #(
  parameter int  BLK_W          = 16,
  parameter int  FRAME_W        = 240,
  parameter int  FRAME_BLK_ROWS = 30,
  parameter int  BUF_BLK_ROWS   = 6,
  parameter int  MAX_INFLIGHT   = 2,
  localparam int BLOCKS_PER_ROW = FRAME_W / BLK_W,
  localparam int COL_W          = $clog2(BLOCKS_PER_ROW),
  localparam int ROW_W          = $clog2(FRAME_BLK_ROWS),
  localparam int CRED_W         = $clog2(BUF_BLK_ROWS + 1),
  localparam int INFL_W         = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_frame_start,
  output logic             o_job_valid,
  input  logic             i_job_ready,
  output logic [COL_W-1:0] o_job_col,
  output logic [ROW_W-1:0] o_job_row,
  output logic             o_job_last,
  input  logic             i_result_valid,
  input  logic             i_row_consumed,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(BLOCKS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(FRAME_BLK_ROWS - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_BLK_ROWS);
  localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFLIGHT);

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [CRED_W-1:0] r_credits;
  logic [CRED_W-1:0] w_credits_nxt;
  logic [INFL_W-1:0] r_inflight;
  logic [INFL_W-1:0] w_inflight_nxt;
  logic              r_frame_done;
  logic              r_err;
  logic              w_xfer;
  logic              w_take;
  logic              w_load;
  logic              w_done;
  logic              w_err_set;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= '0;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Column 0 opens a new block row in the downstream buffer, so only it needs a credit.
  assign o_job_valid  = (r_state == S_ISSUE) && (r_inflight < INFL_MAX) &&
                        ((r_col != '0) || (r_credits != '0));
  assign o_job_col    = r_col;
  assign o_job_row    = r_row;
  assign o_job_last   = (r_col == LAST_COL) && (r_row == LAST_ROW);
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;

  assign w_xfer = o_job_valid && i_job_ready;
  assign w_take = w_xfer && (r_col == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_frame_start) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_xfer && o_job_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (i_result_valid && (r_inflight == INFL_W'(1))) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_inflight_nxt = r_inflight;
    w_credits_nxt  = r_credits;
    w_err_set      = i_frame_start && (r_state != S_IDLE);
    case ({w_xfer, i_result_valid})
      2'b10:   w_inflight_nxt = r_inflight + 1'b1;
      2'b01: begin
        if (r_inflight == '0) w_err_set = 1'b1;
        else                  w_inflight_nxt = r_inflight - 1'b1;
      end
      default: w_inflight_nxt = r_inflight;
    endcase
    // A credit returned at full capacity is a streamer protocol error; hold rather than wrap.
    case ({w_take, i_row_consumed})
      2'b10:   w_credits_nxt = r_credits - 1'b1;
      2'b01: begin
        if (r_credits == CRED_MAX) w_err_set = 1'b1;
        else                       w_credits_nxt = r_credits + 1'b1;
      end
      default: w_credits_nxt = r_credits;
    endcase
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_credits    <= CRED_MAX;
      r_inflight   <= '0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_credits    <= w_credits_nxt;
      r_inflight   <= w_inflight_nxt;
      r_frame_done <= w_done;
      if (w_err_set) r_err <= 1'b1;
      if (w_load) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_xfer) begin
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= o_job_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_match_job_scheduler.sv
// Randomised and directed checks of match_job_scheduler against a frame-level model (job index, credit and in-flight tallies).
module tb_match_job_scheduler;

  localparam int BPR   = 4;
  localparam int ROWS  = 3;
  localparam int TOTAL = BPR * ROWS;
  localparam int BUF   = 2;
  localparam int MAXI  = 2;

  logic       clk = 1'b0;
  logic       i_reset_n;
  logic       i_frame_start;
  logic       o_job_valid;
  logic       i_job_ready;
  logic [1:0] o_job_col;
  logic [1:0] o_job_row;
  logic       o_job_last;
  logic       i_result_valid;
  logic       i_row_consumed;
  logic       o_busy;
  logic       o_frame_done;
  logic       o_err;

  match_job_scheduler #(
    .BLK_W(16), .FRAME_W(64), .FRAME_BLK_ROWS(ROWS), .BUF_BLK_ROWS(BUF), .MAX_INFLIGHT(MAXI)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_frame_start(i_frame_start),
    .o_job_valid(o_job_valid), .i_job_ready(i_job_ready),
    .o_job_col(o_job_col), .o_job_row(o_job_row), .o_job_last(o_job_last),
    .i_result_valid(i_result_valid), .i_row_consumed(i_row_consumed),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfers = 0;
  int dones = 0;

  // Frame-level model: next job index, credits, jobs outstanding, frame phase.
  int m_n = 0;
  int m_credits = BUF;
  int m_inflight = 0;
  bit m_busy = 0;
  bit m_err = 0;
  bit m_done = 0;
  int due_q[$];

  bit withhold = 0, force_rv = 0, force_rc = 0, force_fs = 0;
  bit auto_rc = 0, auto_fs = 0, rand_ready = 0, ready_level = 1;
  int dly_min = 3, dly_max = 3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit rv, rc, fs, rdy, exp_valid, xfer, take, done_now;
    int infl, cred;
    if (o_frame_done === 1'b1) dones++;
    rv = 1'b0;
    if (force_rv) begin
      rv = 1'b1;
      if (due_q.size() > 0) void'(due_q.pop_front());
    end else if (!withhold && due_q.size() > 0 && due_q[0] <= cyc) begin
      rv = 1'b1;
      void'(due_q.pop_front());
    end
    rc  = force_rc || (auto_rc && m_credits < BUF && $urandom_range(3) == 0);
    fs  = force_fs || (auto_fs && !m_busy && $urandom_range(1) == 0);
    rdy = rand_ready ? 1'($urandom_range(1)) : ready_level;
    i_result_valid = rv;
    i_row_consumed = rc;
    i_frame_start  = fs;
    i_job_ready    = rdy;

    exp_valid = m_busy && m_n < TOTAL && m_inflight < MAXI && ((m_n % BPR) != 0 || m_credits > 0);
    chk("job_valid", 32'(o_job_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("job_col", 32'(o_job_col), 32'(m_n % BPR));
      chk("job_row", 32'(o_job_row), 32'(m_n / BPR));
      chk("job_last", 32'(o_job_last), 32'(m_n == TOTAL - 1));
    end
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("frame_done", 32'(o_frame_done), 32'(m_done));
    chk("err", 32'(o_err), 32'(m_err));
    if (o_job_valid && rdy) xfers++;

    xfer = exp_valid && rdy;
    take = xfer && (m_n % BPR == 0);
    if (xfer) begin
      due_q.push_back(cyc + $urandom_range(dly_min, dly_max));
      m_n++;
    end
    infl = m_inflight + int'(xfer);
    if (rv) begin
      if (infl == 0) m_err = 1'b1;
      else infl--;
    end
    cred = m_credits - int'(take);
    if (rc) begin
      if (cred == BUF) m_err = 1'b1;
      else cred++;
    end
    done_now = m_busy && m_n == TOTAL && rv && infl == 0;
    m_done = 1'b0;
    if (fs && m_busy) m_err = 1'b1;
    if (fs && !m_busy) begin
      m_busy = 1'b1;
      m_n = 0;
    end
    if (done_now) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    m_inflight = infl;
    m_credits = cred;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic quiet();
    force_rv = 0; force_rc = 0; force_fs = 0; auto_rc = 0; auto_fs = 0;
    i_frame_start = 0; i_result_valid = 0; i_row_consumed = 0;
  endtask

  // Called at a sample point; asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(o_job_valid), 0);
    chk({tag, "_col"}, 32'(o_job_col), 0);
    chk({tag, "_row"}, 32'(o_job_row), 0);
    chk({tag, "_last"}, 32'(o_job_last), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_done"}, 32'(o_frame_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    quiet();
    m_n = 0; m_credits = BUF; m_inflight = 0; m_busy = 0; m_err = 0; m_done = 0;
    due_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic run_frame(input string tag);
    int d0;
    d0 = dones;
    withhold = 0; rand_ready = 0; ready_level = 1; dly_min = 3; dly_max = 3; auto_rc = 1;
    force_fs = 1; cycle(); force_fs = 0;
    repeat (70) cycle();
    auto_rc = 0;
    chk({tag, "_frames"}, 32'(dones - d0), 1);
    chk({tag, "_busy"}, 32'(o_busy), 0);
  endtask

  initial begin
    int x0, d0;
    i_reset_n = 1'b1;
    i_frame_start = 0; i_job_ready = 1; i_result_valid = 0; i_row_consumed = 0;
    #3;
    i_reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(o_job_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_done", 32'(o_frame_done), 0);
    chk("rst_col", 32'(o_job_col), 0);
    chk("rst_row", 32'(o_job_row), 0);
    chk("rst_last", 32'(o_job_last), 0);
    repeat (3) @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    repeat (3) cycle();

    // Frame runs out of credits after two block rows.
    xfers = 0;
    force_fs = 1; cycle(); force_fs = 0;
    repeat (30) cycle();
    chk("stall_xfers", 32'(xfers), 8);
    chk("stall_busy", 32'(o_busy), 1);
    chk("stall_valid", 32'(o_job_valid), 0);
    chk("stall_col", 32'(o_job_col), 0);
    chk("stall_row", 32'(o_job_row), 2);
    chk("stall_dones", 32'(dones), 0);

    // One returned credit lets the last row through and the frame drains.
    force_rc = 1; cycle(); force_rc = 0;
    repeat (30) cycle();
    chk("frame_xfers", 32'(xfers), 12);
    chk("frame_dones", 32'(dones), 1);
    chk("frame_busy", 32'(o_busy), 0);
    chk("frame_err", 32'(o_err), 0);

    // In-flight cap with results withheld.
    force_rc = 1; repeat (2) cycle(); force_rc = 0;
    withhold = 1;
    x0 = xfers;
    force_fs = 1; cycle(); force_fs = 0;
    repeat (6) cycle();
    chk("cap_xfers", 32'(xfers - x0), 2);
    chk("cap_valid", 32'(o_job_valid), 0);
    x0 = xfers;
    force_rv = 1; cycle(); force_rv = 0;
    chk("cap_reopen_valid", 32'(o_job_valid), 1);
    repeat (3) cycle();
    chk("cap_one_more", 32'(xfers - x0), 1);

    // job_ready held low: model checks coordinates hold every cycle.
    withhold = 0; ready_level = 0;
    repeat (8) cycle();
    chk("hold_valid", 32'(o_job_valid), 1);
    x0 = xfers;
    ready_level = 1;
    cycle();
    chk("hold_release_xfer", 32'(xfers - x0), 1);

    // Randomised traffic across several frames.
    d0 = dones;
    rand_ready = 1; dly_min = 1; dly_max = 5; auto_rc = 1; auto_fs = 1;
    repeat (400) cycle();
    auto_fs = 0; rand_ready = 0; ready_level = 1;
    repeat (150) cycle();
    auto_rc = 0;
    chk("rand_frames", 32'(dones - d0 > 1), 1);
    chk("rand_busy", 32'(o_busy), 0);
    chk("rand_err", 32'(o_err), 0);

    // Extra row_consumed at full credits; credits must not wrap.
    do_reset("r1");
    force_rc = 1; cycle(); force_rc = 0;
    chk("abuse_rc_err", 32'(o_err), 1);
    run_frame("post_rc");

    // Extra result_valid with nothing in flight; inflight must not wrap.
    do_reset("r2");
    force_rv = 1; cycle(); force_rv = 0;
    chk("abuse_rv_err", 32'(o_err), 1);
    run_frame("post_rv");

    // frame_start while busy, then reset mid-frame.
    do_reset("r3");
    dly_min = 3; dly_max = 3;
    force_fs = 1; cycle(); force_fs = 0;
    repeat (3) cycle();
    force_fs = 1; cycle(); force_fs = 0;
    repeat (2) cycle();
    chk("abuse_fs_err", 32'(o_err), 1);
    chk("abuse_fs_busy", 32'(o_busy), 1);
    do_reset("midframe");
    run_frame("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
